mu0_ctrl_seq: RTL
=================

Name: mu0_ctrl_seq

Overview:
- Fetch/execute control sequencer for the MU0 datapath with index register.
- Decodes the 4-bit opcode held in IR and drives all datapath clock enables, including idxce for the index register, plus ALU function, operand/address mux selects and the memory request handshake.
- Updates on the rising clk edge. The datapath registers (IR, PC, ACC, IDX) capture on the falling edge of the same cycle, so the enables are stable for half a cycle before they are used.

Parameters:
- MEM_TIMEOUT, 15: max cycles mem_req may wait for mem_rdy before bus error.
- TO_W, 4: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- ir_op  in  4  IR[15:12], the current opcode.
- acc_z  in  1  ACC == 0.
- acc_n  in  1  ACC[15], the sign bit.
- mem_rdy  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_rw  out  1  1 = write, 0 = read.
- addr_sel  out  2  0 = PC, 1 = IR[11:0], 2 = IR[11:0] + IDX (12-bit wrap).
- a_sel  out  1  ALU A operand: 0 = ACC, 1 = IDX.
- b_sel  out  2  ALU B operand: 0 = mem data, 1 = PC, 2 = IR[11:0].
- alufs  out  3  ALU function code (codes in package).
- irce, pcce, accce, idxce, acc_oe  out  1 each  register enables; acc_oe drives ACC onto the write bus.
- halted  out  1  sticky; set on STP, illegal opcode or timeout.
- err  out  2  0 = none, 1 = illegal opcode, 2 = bus timeout.

Behaviour:
- States: RST, FETCH, EXEC, HALT. While reset=1, and for the one cycle in RST after reset falls, every output is 0. RST always goes to FETCH.
- Reset asserted in any state, including mid-wait: next state RST, wait counter cleared, mem_req low from the next cycle, halted and err cleared.
- FETCH: mem_req=1, mem_rw=0, addr_sel=PC. The cycle mem_rdy=1 asserts irce=1, pcce=1, b_sel=PC, alufs=INC_B, then goes to EXEC. With zero wait states, FETCH lasts 1 cycle.
- EXEC, decoded from ir_op:
  - 0 LDA: read addr IR, PASS_B with b=mem, accce.
  - 1 STA: write addr IR, acc_oe.
  - 2 ADD / 3 SUB: read addr IR, a=ACC, b=mem, ADD/SUB, accce.
  - 4 JMP: b=IR, PASS_B, pcce. No memory access.
  - 5 JGE: as JMP only if acc_n=0, else no enables.
  - 6 JNE: as JMP only if acc_z=0, else no enables.
  - 7 STP: go to HALT.
  - 8 LDX: read addr IR, PASS_B, idxce.
  - 9 INX: a=IDX, INC_A, idxce.
  - A DEX: a=IDX, DEC_A, idxce. IDX wraps 0x000 -> 0xFFF.
  - B LAX: read addr IR+IDX, PASS_B, accce.
  - C SAX: write addr IR+IDX, acc_oe.
  - D, E, F: illegal. Go to HALT with err=1; no enables asserted.
- Memory ops in EXEC:
  - mem_req is held with constant addr_sel, mem_rw and b_sel until mem_rdy.
  - Register enables assert only in the mem_rdy cycle; acc_oe is held for the whole write request.
  - Non-memory ops complete in 1 EXEC cycle. Every completion returns to FETCH.
- Wait counter:
  - Counts cycles with mem_req=1 and mem_rdy=0; clears on mem_rdy or on leaving the state.
  - When the count reaches MEM_TIMEOUT with mem_rdy still 0: next state HALT, err=2, no enables asserted in that cycle.
  - mem_rdy=1 in the same cycle the count reaches MEM_TIMEOUT: the access completes normally.
- mem_rdy while mem_req=0 is ignored.
- HALT: all outputs 0 except halted=1 and err. Leaves only on reset.
- No opcode ever asserts two of irce/accce/idxce in the same cycle.

Decomposition:
- Shared package mu0_pkg:
  - opcode constants OP_LDA..OP_SAX
  - ALU codes ALU_PASS_B=0, ADD=1, SUB=2, INC_A=3, DEC_A=4, INC_B=5
  - addr_sel / b_sel / err encodings
  - state enum
- One sub-module, mu0_dec: combinational opcode -> control-word decode (needs_mem, is_write, dest enables, selects, alufs).
- mu0_ctrl_seq keeps the FSM, wait counter and mem_rdy gating.

Test Plan:
- Reset held 3 cycles, then released with mem_rdy=1: all outputs 0 for the reset cycles and the RST cycle. Next cycle mem_req=1, addr_sel=0, irce=pcce=1, alufs=5.
- ir_op=8 (LDX), mem_rdy low 2 cycles then high: mem_req=1, addr_sel=1 for 3 cycles; idxce=1 only in the 3rd cycle; then FETCH.
- ir_op=9 then ir_op=A: idxce=1, a_sel=1, alufs=3 then 4, each in a single EXEC cycle with mem_req=0.
- ir_op=C (SAX), mem_rdy=1: mem_req=1, mem_rw=1, addr_sel=2, acc_oe=1; no enables asserted.
- ir_op=5 with acc_n=1: no pcce. ir_op=5 with acc_n=0: pcce=1, b_sel=2. ir_op=E: halted=1, err=1, and halted stays 1 for 20 cycles.
- FETCH with mem_rdy stuck 0: after 15 wait cycles, halted=1, err=2. Separately, reset asserted at wait cycle 7: mem_req=0 the next cycle and FETCH restarts cleanly.

Source files
------------

// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared opcodes, ALU codes, select encodings, state enum and control word
package mu0_pkg;

  // Opcodes held in IR[15:12]; 0xD..0xF are illegal.
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDX = 4'h8;
  localparam logic [3:0] OP_INX = 4'h9;
  localparam logic [3:0] OP_DEX = 4'hA;
  localparam logic [3:0] OP_LAX = 4'hB;
  localparam logic [3:0] OP_SAX = 4'hC;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_INC_A  = 3'd3;
  localparam logic [2:0] ALU_DEC_A  = 3'd4;
  localparam logic [2:0] ALU_INC_B  = 3'd5;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_IR  = 2'd1;
  localparam logic [1:0] ADDR_IDX = 2'd2;

  localparam logic       A_ACC = 1'b0;
  localparam logic       A_IDX = 1'b1;

  localparam logic [1:0] B_MEM = 2'd0;
  localparam logic [1:0] B_PC  = 2'd1;
  localparam logic [1:0] B_IR  = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Decoded EXEC control word. Enables here are unqualified; the sequencer
  // gates them with mem_rdy for memory ops.
  typedef struct packed {
    logic       needs_mem;
    logic       is_write;
    logic [1:0] addr_sel;
    logic       a_sel;
    logic [1:0] b_sel;
    logic [2:0] alufs;
    logic       pcce;
    logic       accce;
    logic       idxce;
    logic       stop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mu0_ctrl_seq_if.sv
// rtl/mu0_ctrl_seq_if.sv - control bus between sequencer (master) and datapath/memory (slave)
// Inputs to sequencer: ir_op, acc_z, acc_n, mem_rdy.
// Outputs from sequencer: memory handshake, selects, ALU function, enables, status.
interface mu0_ctrl_seq_if;
  logic [3:0] ir_op;
  logic       acc_z;
  logic       acc_n;
  logic       mem_rdy;
  logic       mem_req;
  logic       mem_rw;
  logic [1:0] addr_sel;
  logic       a_sel;
  logic [1:0] b_sel;
  logic [2:0] alufs;
  logic       irce;
  logic       pcce;
  logic       accce;
  logic       idxce;
  logic       acc_oe;
  logic       halted;
  logic [1:0] err;

  modport master (
    input  ir_op, acc_z, acc_n, mem_rdy,
    output mem_req, mem_rw, addr_sel, a_sel, b_sel, alufs,
           irce, pcce, accce, idxce, acc_oe, halted, err
  );

  modport slave (
    output ir_op, acc_z, acc_n, mem_rdy,
    input  mem_req, mem_rw, addr_sel, a_sel, b_sel, alufs,
           irce, pcce, accce, idxce, acc_oe, halted, err
  );
endinterface

// File: rtl/mu0_dec.sv
// rtl/mu0_dec.sv - combinational opcode to EXEC control word decode
// ir_op_i: opcode; acc_z_i/acc_n_i: ACC flags for conditional jumps; ctrl_o: control word.
module mu0_dec
  import mu0_pkg::*;
(
  input  logic [3:0] ir_op_i,
  input  logic       acc_z_i,
  input  logic       acc_n_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (ir_op_i)
      OP_LDA: begin
        ctrl_o.needs_mem = 1'b1;
        ctrl_o.addr_sel  = ADDR_IR;
        ctrl_o.accce     = 1'b1;
      end
      OP_STA: begin
        ctrl_o.needs_mem = 1'b1;
        ctrl_o.is_write  = 1'b1;
        ctrl_o.addr_sel  = ADDR_IR;
      end
      OP_ADD, OP_SUB: begin
        ctrl_o.needs_mem = 1'b1;
        ctrl_o.addr_sel  = ADDR_IR;
        ctrl_o.a_sel     = A_ACC;
        ctrl_o.alufs     = (ir_op_i == OP_ADD) ? ALU_ADD : ALU_SUB;
        ctrl_o.accce     = 1'b1;
      end
      // Untaken branches keep the jump selects but drop pcce.
      OP_JMP, OP_JGE, OP_JNE: begin
        ctrl_o.b_sel = B_IR;
        ctrl_o.pcce  = (ir_op_i == OP_JMP) ||
                       (ir_op_i == OP_JGE && !acc_n_i) ||
                       (ir_op_i == OP_JNE && !acc_z_i);
      end
      OP_STP: ctrl_o.stop = 1'b1;
      OP_LDX: begin
        ctrl_o.needs_mem = 1'b1;
        ctrl_o.addr_sel  = ADDR_IR;
        ctrl_o.idxce     = 1'b1;
      end
      OP_INX, OP_DEX: begin
        ctrl_o.a_sel = A_IDX;
        ctrl_o.alufs = (ir_op_i == OP_INX) ? ALU_INC_A : ALU_DEC_A;
        ctrl_o.idxce = 1'b1;
      end
      OP_LAX: begin
        ctrl_o.needs_mem = 1'b1;
        ctrl_o.addr_sel  = ADDR_IDX;
        ctrl_o.accce     = 1'b1;
      end
      OP_SAX: begin
        ctrl_o.needs_mem = 1'b1;
        ctrl_o.is_write  = 1'b1;
        ctrl_o.addr_sel  = ADDR_IDX;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_ctrl_seq.sv
// rtl/mu0_ctrl_seq.sv - MU0 fetch/execute sequencer with index register and memory timeout
// clk: rising-edge clock; reset: synchronous active-high; bus: master side of mu0_ctrl_seq_if.
module mu0_ctrl_seq
  import mu0_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  mu0_ctrl_seq_if.master    bus
);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [1:0]        err_q, err_d;
  ctrl_t             dec;
  logic              in_mem;
  logic              timeout;
  logic              go;

  mu0_dec u_dec (
    .ir_op_i (bus.ir_op),
    .acc_z_i (bus.acc_z),
    .acc_n_i (bus.acc_n),
    .ctrl_o  (dec)
  );

  // mem_req is high in this cycle; mem_rdy only counts while it is.
  assign in_mem  = (state_q == ST_FETCH) || (state_q == ST_EXEC && dec.needs_mem);
  // Timeout fires only once the full wait budget is spent and the
  // memory still has not answered; a late mem_rdy still wins.
  assign timeout = in_mem && !bus.mem_rdy && (wait_q == TO_W'(MEM_TIMEOUT));
  // Enables allowed this cycle: non-memory ops always, memory ops on mem_rdy.
  assign go      = !dec.needs_mem || bus.mem_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    err_d   = err_q;
    unique case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH, ST_EXEC: begin
        if (timeout) begin
          state_d = ST_HALT;
          err_d   = ERR_TIMEOUT;
        end else if (in_mem && !bus.mem_rdy) begin
          wait_d = wait_q + 1'b1;
        end else if (state_q == ST_FETCH) begin
          state_d = ST_EXEC;
        end else if (dec.illegal) begin
          state_d = ST_HALT;
          err_d   = ERR_ILLEGAL;
        end else if (dec.stop) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_rw   = 1'b0;
    bus.addr_sel = ADDR_PC;
    bus.a_sel    = A_ACC;
    bus.b_sel    = B_MEM;
    bus.alufs    = ALU_PASS_B;
    bus.irce     = 1'b0;
    bus.pcce     = 1'b0;
    bus.accce    = 1'b0;
    bus.idxce    = 1'b0;
    bus.acc_oe   = 1'b0;
    bus.halted   = 1'b0;
    bus.err      = ERR_NONE;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_rdy) begin
            bus.irce  = 1'b1;
            bus.pcce  = 1'b1;
            bus.b_sel = B_PC;
            bus.alufs = ALU_INC_B;
          end
        end
        ST_EXEC: begin
          bus.mem_req  = dec.needs_mem;
          bus.mem_rw   = dec.is_write;
          bus.addr_sel = dec.addr_sel;
          bus.a_sel    = dec.a_sel;
          bus.b_sel    = dec.b_sel;
          bus.alufs    = dec.alufs;
          bus.acc_oe   = dec.is_write;
          bus.pcce     = dec.pcce  && go;
          bus.accce    = dec.accce && go;
          bus.idxce    = dec.idxce && go;
        end
        ST_HALT: begin
          bus.halted = 1'b1;
          bus.err    = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule
